// File: rtl/sequenciador_espera.sv
// rtl/sequenciador_espera.sv - stall sequencer for the Delay, Entrada and Saida control strobes
// Holds the PC while a timed delay runs or a switch input waits for the confirm button.
module sequenciador_espera #(
  parameter int WIDTH        = 32,
  parameter int CLK_POR_UNID = 50000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             delay,
  input  logic             entrada,
  input  logic             saida,
  input  logic [WIDTH-1:0] valor_delay,
  input  logic [WIDTH-1:0] dado_saida,
  input  logic [WIDTH-1:0] chaves,
  input  logic             botao,
  output logic             parar,
  output logic             escreve_ent,
  output logic [WIDTH-1:0] dado_entrada,
  output logic [WIDTH-1:0] saida_reg,
  output logic             saida_valida,
  output logic             aguardando
);

  localparam int PW = (CLK_POR_UNID > 1) ? $clog2(CLK_POR_UNID) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_POR_UNID - 1);

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ATRASO     = 2'd1,
    ESPERA_ENT = 2'd2,
    FIM        = 2'd3
  } estado_t;

  estado_t          estado, prox;
  logic [WIDTH-1:0] contador, contador_prox;
  logic [PW-1:0]    prescaler, prescaler_prox;
  logic             arm, arm_prox;
  logic             b_s1, b_s2, b_s3;
  logic             botao_pulso;
  logic             captura;
  logic             carrega_saida;

  // Two-flop synchroniser plus one delay flop for the rising-edge detector
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
      b_s3 <= 1'b0;
    end else begin
      b_s1 <= botao;
      b_s2 <= b_s1;
      b_s3 <= b_s2;
    end
  end

  assign botao_pulso = b_s2 & ~b_s3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= OCIOSO;
      contador     <= '0;
      prescaler    <= '0;
      arm          <= 1'b0;
      dado_entrada <= '0;
      saida_reg    <= '0;
      saida_valida <= 1'b0;
    end else begin
      estado       <= prox;
      contador     <= contador_prox;
      prescaler    <= prescaler_prox;
      arm          <= arm_prox;
      saida_valida <= carrega_saida;
      if (captura)       dado_entrada <= chaves;
      if (carrega_saida) saida_reg    <= dado_saida;
    end
  end

  always_comb begin
    prox           = estado;
    contador_prox  = contador;
    prescaler_prox = prescaler;
    arm_prox       = arm;
    parar          = 1'b0;
    aguardando     = 1'b0;
    escreve_ent    = 1'b0;
    captura        = 1'b0;
    carrega_saida  = 1'b0;
    case (estado)
      OCIOSO: begin
        arm_prox = 1'b0;
        // A zero-length delay still wins priority but behaves as a NOP
        if (delay) begin
          if (valor_delay != '0) begin
            parar          = 1'b1;
            contador_prox  = valor_delay;
            prescaler_prox = PRE_MAX;
            prox           = ATRASO;
          end
        end else if (entrada) begin
          parar = 1'b1;
          prox  = ESPERA_ENT;
        end else if (saida) begin
          carrega_saida = 1'b1;
        end
      end
      ATRASO: begin
        parar = 1'b1;
        if (prescaler == '0) begin
          prescaler_prox = PRE_MAX;
          if (contador == WIDTH'(1)) prox = FIM;
          else contador_prox = contador - WIDTH'(1);
        end else begin
          prescaler_prox = prescaler - PW'(1);
        end
      end
      ESPERA_ENT: begin
        parar      = 1'b1;
        aguardando = 1'b1;
        if (botao_pulso) begin
          captura  = 1'b1;
          arm_prox = 1'b1;
          prox     = FIM;
        end
      end
      FIM: begin
        escreve_ent = arm;
        arm_prox    = 1'b0;
        prox        = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_sequenciador_espera.sv
// tb/tb_sequenciador_espera.sv - scoreboard bench for sequenciador_espera
// Stimulus pushes expected stall lengths, captures and display updates; a negedge monitor checks them.
module tb_sequenciador_espera;

  localparam int W = 32;
  localparam int CPU = 4;
  localparam int K_STALL = 0;
  localparam int K_ENT = 1;
  localparam int K_SAI = 2;

  typedef struct {
    int          kind;
    logic [31:0] value;
  } ev_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         delay, entrada, saida, botao;
  logic [W-1:0] valor_delay, dado_saida, chaves;
  logic         parar, escreve_ent, saida_valida, aguardando;
  logic [W-1:0] dado_entrada, saida_reg;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  sequenciador_espera #(.WIDTH(W), .CLK_POR_UNID(CPU)) dut (
    .clock(clock), .reset_n(reset_n),
    .delay(delay), .entrada(entrada), .saida(saida),
    .valor_delay(valor_delay), .dado_saida(dado_saida), .chaves(chaves), .botao(botao),
    .parar(parar), .escreve_ent(escreve_ent), .dado_entrada(dado_entrada),
    .saida_reg(saida_reg), .saida_valida(saida_valida), .aguardando(aguardando)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push(input int k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [31:0] v);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d value %h expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.value !== v) begin
        n_bad++;
        $display("FAIL event: got kind %0d value %h expected kind %0d value %h", k, v, e.kind, e.value);
      end
    end
  endtask

  // Monitor: stall run lengths, escreve_ent pulses and saida_valida pulses
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        run = 0;
      end else begin
        if (parar) run++;
        else if (run != 0) begin
          check_ev(K_STALL, run);
          run = 0;
        end
        if (escreve_ent)  check_ev(K_ENT, dado_entrada);
        if (saida_valida) check_ev(K_SAI, saida_reg);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_parar_low(input string nm);
    int n;
    n = 0;
    while (parar && n < 200) begin
      tick();
      n++;
    end
    if (parar) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: parar still 1 expected 0", nm);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_parar"}, {31'd0, parar}, 32'd0);
    chk({nm, "_escreve"}, {31'd0, escreve_ent}, 32'd0);
    chk({nm, "_aguard"}, {31'd0, aguardando}, 32'd0);
    chk({nm, "_valida"}, {31'd0, saida_valida}, 32'd0);
    chk({nm, "_dado_ent"}, dado_entrada, 32'd0);
    chk({nm, "_saida_reg"}, saida_reg, 32'd0);
  endtask

  // Entrada with button pressed after 5 waiting clocks: 1 decode + 8 waiting = 9 stalled clocks
  task automatic do_input(input string nm, input logic [31:0] sw);
    chaves = sw;
    push(K_STALL, 9);
    push(K_ENT, sw);
    entrada = 1'b1;
    #0;
    chk({nm, "_parar_decode"}, {31'd0, parar}, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk({nm, "_aguard"}, {31'd0, aguardando}, 32'd1);
      tick();
    end
    botao = 1'b1;
    wait_parar_low(nm);
    chk({nm, "_fim_escreve"}, {31'd0, escreve_ent}, 32'd1);
    chk({nm, "_fim_dado"}, dado_entrada, sw);
    entrada = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({nm, "_held_parar"}, {31'd0, parar}, 32'd0);
    end
    botao = 1'b0;
    tick();
    chk({nm, "_dado_hold"}, dado_entrada, sw);
  endtask

  initial begin
    reset_n = 1'b0;
    delay = 1'b0; entrada = 1'b0; saida = 1'b0; botao = 1'b0;
    valor_delay = '0; dado_saida = '0; chaves = '0;
    repeat (2) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // 1: delay of 3 units -> 13 stalled clocks then FIM
    valor_delay = 32'd3;
    push(K_STALL, 13);
    delay = 1'b1;
    #0;
    chk("t1_parar_decode", {31'd0, parar}, 32'd1);
    tick();
    wait_parar_low("t1");
    chk("t1_fim_escreve", {31'd0, escreve_ent}, 32'd0);
    delay = 1'b0;
    tick();
    chk("t1_ocioso_parar", {31'd0, parar}, 32'd0);

    // 2: zero-length delay is a NOP
    valor_delay = 32'd0;
    delay = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #0;
      chk("t2_parar", {31'd0, parar}, 32'd0);
      tick();
    end
    delay = 1'b0;
    tick();

    // 3: input capture, single pulse despite held button
    do_input("t3", 32'h0000_00A5);

    // 4: display latch
    dado_saida = 32'h0000_1234;
    push(K_SAI, 32'h0000_1234);
    saida = 1'b1;
    #0;
    chk("t4_parar", {31'd0, parar}, 32'd0);
    tick();
    chk("t4_saida_reg", saida_reg, 32'h0000_1234);
    chk("t4_parar_after", {31'd0, parar}, 32'd0);
    saida = 1'b0;
    tick();
    chk("t4_valida_once", {31'd0, saida_valida}, 32'd0);

    // 5: all strobes together -> delay of 1 unit, 1+4 stalled clocks, display untouched
    valor_delay = 32'd1;
    dado_saida = 32'h0000_FFFF;
    push(K_STALL, 5);
    delay = 1'b1; entrada = 1'b1; saida = 1'b1;
    tick();
    wait_parar_low("t5");
    delay = 1'b0; entrada = 1'b0; saida = 1'b0;
    tick();
    chk("t5_saida_reg", saida_reg, 32'h0000_1234);

    // 6a: reset in the middle of a delay
    valor_delay = 32'd5;
    delay = 1'b1;
    repeat (6) tick();
    chk("t6a_stalled", {31'd0, parar}, 32'd1);
    reset_n = 1'b0;
    delay = 1'b0;
    #1;
    check_zero("t6a");
    tick();
    reset_n = 1'b1;
    tick();

    // 6b: reset while waiting for the button
    entrada = 1'b1;
    repeat (3) tick();
    chk("t6b_aguard", {31'd0, aguardando}, 32'd1);
    reset_n = 1'b0;
    entrada = 1'b0;
    #1;
    check_zero("t6b");
    tick();
    reset_n = 1'b1;
    tick();

    // Button press in OCIOSO must be forgotten
    botao = 1'b1;
    repeat (4) begin
      tick();
      chk("t6_idle_parar", {31'd0, parar}, 32'd0);
    end
    botao = 1'b0;
    repeat (4) tick();
    do_input("t6_after", 32'h0000_003C);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
